// File: rtl/riscv_wb_loadq.sv
// -----------------------------------------------------------------------------
// riscv_wb_loadq
//   In-order writeback queue that sits between the memory stage and the
//   register file. Instructions enter in program order; non-load entries may
//   retire as soon as they reach the head. Load entries wait for their in-order
//   data-memory response. A response may also retire the head load in the same
//   cycle it arrives (bypass).
//
//   A faulting load, or a flush, discards every younger entry. Loads that were
//   already issued but never answered are remembered in a drop counter, so that
//   their late responses are swallowed instead of landing on live loads.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   mem_valid_i/mem_ready_o   enqueue handshake from the memory stage
//   mem_pc_i, mem_dst_i       PC and destination register of the instruction
//   mem_r_i                   execute result (non-load instructions)
//   mem_load_i                instruction is a load awaiting a response
//   mem_size_i                load size: 0 byte, 1 half, 2 word, 3 double
//   mem_unsigned_i            zero-extend the loaded value
//   mem_memadr_i              load address (alignment and fault reporting)
//   dmem_ack_i/dmem_err_i     in-order load response / access fault
//   dmem_q_i                  raw response data
//   flush_i                   discard all queued instructions
//   wb_valid_o                single-cycle retire strobe
//   wb_we_o, wb_err_o         register write enable, load fault
//   wb_pc_o, wb_dst_o, wb_r_o retired PC, destination and write data
//   wb_badaddr_o              address of the last faulting load
//   occupancy_o               number of live queue entries
// -----------------------------------------------------------------------------
module riscv_wb_loadq #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     DEPTH   = 4,
  parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [XLEN-1:0]          mem_pc_i,
  input  logic [4:0]               mem_dst_i,
  input  logic [XLEN-1:0]          mem_r_i,
  input  logic                     mem_load_i,
  input  logic [1:0]               mem_size_i,
  input  logic                     mem_unsigned_i,
  input  logic [XLEN-1:0]          mem_memadr_i,
  input  logic                     dmem_ack_i,
  input  logic                     dmem_err_i,
  input  logic [XLEN-1:0]          dmem_q_i,
  input  logic                     flush_i,
  output logic                     wb_valid_o,
  output logic                     wb_we_o,
  output logic                     wb_err_o,
  output logic [XLEN-1:0]          wb_pc_o,
  output logic [XLEN-1:0]          wb_r_o,
  output logic [XLEN-1:0]          wb_badaddr_o,
  output logic [4:0]               wb_dst_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int unsigned PTRW  = $clog2(DEPTH);
  localparam int unsigned CNTW  = PTRW + 1;
  // Drops accumulate across back-to-back flushes, so give headroom above DEPTH.
  localparam int unsigned DROPW = PTRW + 4;
  // Byte offset inside an XLEN word used to align load data.
  localparam int unsigned OFFW  = (XLEN == 64) ? 3 : 2;

  typedef logic [PTRW-1:0] ptr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      dst;
    logic [XLEN-1:0] r;     // execute result, or raw load data once answered
    logic [XLEN-1:0] adr;
    logic            load;
    logic [1:0]      size;
    logic            uns;
    logic            resp;  // load response has been stored
    logic            err;
  } entry_t;

  entry_t           q [DEPTH];
  ptr_t             head, tail;
  logic [CNTW-1:0]  count;
  logic [DROPW-1:0] drop_cnt;

  ptr_t             slot [DEPTH];  // queue index of the k-th oldest entry
  logic             live [DEPTH];
  logic             pend_after [DEPTH];

  entry_t           hd;
  logic             enq, rsp, rsp_found, rsp_apply, drop_dec;
  ptr_t             rsp_idx;
  logic [CNTW-1:0]  pend_all, pend_young;
  logic             bypass, ret, ret_err, fault, discard;
  logic [XLEN-1:0]  ret_raw, ret_r;
  logic [DROPW-1:0] drop_add, drop_next;

  // Shift the response to the addressed byte lane, truncate to the access
  // size and extend. Building the result at 64 bits keeps one code path for
  // both XLEN values; for XLEN=32 size 3 degenerates to the word case.
  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] data,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [1:0]      size,
                                                 input logic            uns);
    logic [XLEN-1:0] sh;
    logic [63:0]     ext;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    ext = {{56{~uns & sh[7]}},  sh[7:0]};
      2'd1:    ext = {{48{~uns & sh[15]}}, sh[15:0]};
      2'd2:    ext = {{32{~uns & sh[31]}}, sh[31:0]};
      default: ext = 64'(sh);
    endcase
    return ext[XLEN-1:0];
  endfunction

  assign rsp         = dmem_ack_i | dmem_err_i;
  // Readiness looks only at the registered occupancy, so a retirement in this
  // cycle cannot open a slot combinationally.
  assign mem_ready_o = ~rst_i & ~flush_i & (count < CNTW'(DEPTH));
  assign enq         = mem_valid_i & mem_ready_o;
  assign occupancy_o = count;
  assign hd          = q[head];

  // NOTE: combinational blocks use blocking '=' and give every output a value
  //       on every path, so no latches are inferred.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot[k] = head + ptr_t'(k);
      live[k] = CNTW'(k) < count;
    end
  end

  always_comb begin
    // The response target is the oldest live load still waiting for data.
    rsp_found = 1'b0;
    rsp_idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      if (!rsp_found && live[k] && q[slot[k]].load && !q[slot[k]].resp) begin
        rsp_found = 1'b1;
        rsp_idx   = slot[k];
      end
    end
    drop_dec  = rsp & (drop_cnt != '0);
    rsp_apply = rsp & (drop_cnt == '0) & rsp_found;

    // Loads still unanswered after this cycle's response has been applied;
    // these are the ones whose responses must later be dropped.
    pend_all   = '0;
    pend_young = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pend_after[k] = live[k] && q[slot[k]].load && !q[slot[k]].resp &&
                      !(rsp_apply && (rsp_idx == slot[k]));
      pend_all = pend_all + CNTW'(pend_after[k]);
      if (k != 0) pend_young = pend_young + CNTW'(pend_after[k]);
    end

    bypass  = rsp_apply && (rsp_idx == head);
    ret     = (count != '0) && !flush_i && (!hd.load || hd.resp || bypass);
    ret_raw = bypass ? dmem_q_i : hd.r;
    ret_err = hd.load && (bypass ? dmem_err_i : hd.err);
    ret_r   = hd.load ? load_align(ret_raw, hd.adr[OFFW-1:0], hd.size, hd.uns) : hd.r;
    fault   = ret && ret_err;
    discard = flush_i || fault;

    // An instruction accepted in the fault cycle is younger than the faulting
    // load and is discarded with the rest; if it is a load its response is
    // still coming and must be dropped too.
    drop_add = '0;
    if (flush_i)    drop_add = DROPW'(pend_all);
    else if (fault) drop_add = DROPW'(pend_young) + DROPW'(enq & mem_load_i);
    drop_next = drop_cnt - DROPW'(drop_dec) + drop_add;
  end

  // NOTE: queue storage carries no reset; head, tail and count alone decide
  //       which entries are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      q[tail] <= '{pc: mem_pc_i, dst: mem_dst_i, r: mem_r_i, adr: mem_memadr_i,
                   load: mem_load_i, size: mem_size_i, uns: mem_unsigned_i,
                   resp: 1'b0, err: 1'b0};
    end
    if (rsp_apply) begin
      q[rsp_idx].resp <= 1'b1;
      q[rsp_idx].err  <= dmem_err_i;
      q[rsp_idx].r    <= dmem_q_i;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  //       the pre-edge values computed above.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      drop_cnt     <= '0;
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_pc_o      <= PC_INIT;
      wb_dst_o     <= '0;
      wb_r_o       <= '0;
      wb_badaddr_o <= '0;
    end else begin
      if (discard) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + ptr_t'(ret);
        tail  <= tail + ptr_t'(enq);
        count <= count + CNTW'(enq) - CNTW'(ret);
      end
      drop_cnt   <= drop_next;
      wb_valid_o <= ret;
      wb_we_o    <= ret && (hd.dst != 5'd0) && !ret_err;
      wb_err_o   <= fault;
      if (ret) begin
        wb_pc_o  <= hd.pc;
        wb_dst_o <= hd.dst;
        wb_r_o   <= ret_r;
      end
      if (fault) wb_badaddr_o <= hd.adr;
    end
  end

endmodule

// File: tb/tb_riscv_wb_loadq.sv
// -----------------------------------------------------------------------------
// tb_riscv_wb_loadq
//   Self-checking bench for riscv_wb_loadq (XLEN=32, DEPTH=4). A queue-based
//   reference model tracks program-order entries, the drop counter and the
//   expected writeback registers; every cycle the DUT outputs are compared
//   with the model. Directed scenarios cover the documented examples, then a
//   randomized phase mixes enqueues, responses, faults, flushes and resets.
// -----------------------------------------------------------------------------
module tb_riscv_wb_loadq;

  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h200;

  logic        clk = 1'b0;
  logic        rst, mem_valid, mem_load, mem_uns, ack, err, flush;
  logic [31:0] mem_pc, mem_r, mem_adr, q_in;
  logic [4:0]  mem_dst;
  logic [1:0]  mem_size;

  logic        mem_ready_o, wb_valid_o, wb_we_o, wb_err_o;
  logic [31:0] wb_pc_o, wb_r_o, wb_badaddr_o;
  logic [4:0]  wb_dst_o;
  logic [2:0]  occupancy_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_wb_loadq #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready_o),
    .mem_pc_i(mem_pc), .mem_dst_i(mem_dst), .mem_r_i(mem_r),
    .mem_load_i(mem_load), .mem_size_i(mem_size), .mem_unsigned_i(mem_uns),
    .mem_memadr_i(mem_adr),
    .dmem_ack_i(ack), .dmem_err_i(err), .dmem_q_i(q_in),
    .flush_i(flush),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_err_o(wb_err_o),
    .wb_pc_o(wb_pc_o), .wb_r_o(wb_r_o), .wb_badaddr_o(wb_badaddr_o),
    .wb_dst_o(wb_dst_o), .occupancy_o(occupancy_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dst;
    logic [31:0] r;
    logic        load;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] adr;
    bit          got;
    logic        err;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          drop;
  logic        e_valid, e_we, e_err;
  logic [31:0] e_pc, e_r, e_bad;
  logic [4:0]  e_dst;

  function automatic logic [31:0] ref_load(logic [31:0] data, logic [31:0] adr,
                                           logic [1:0] size, logic uns);
    logic [31:0] v;
    v = data >> (8 * adr[1:0]);
    if (size == 2'd0) return uns ? 32'(v[7:0])  : 32'($signed(v[7:0]));
    if (size == 2'd1) return uns ? 32'(v[15:0]) : 32'($signed(v[15:0]));
    return v;  // word; double is treated as word on a 32-bit core
  endfunction

  function automatic int unanswered(int from);
    int n = 0;
    for (int i = from; i < mq.size(); i++)
      if (mq[i].load && !mq[i].got) n++;
    return n;
  endfunction

  function automatic logic exp_ready();
    return !rst && (mq.size() < DEPTH) && !flush;
  endfunction

  task automatic model_step();
    bit   rdy, fault;
    ent_t h, n;
    if (rst) begin
      mq.delete();
      drop = 0;
      e_valid = 0; e_we = 0; e_err = 0;
      e_pc = PC_INIT; e_dst = 0; e_r = 0; e_bad = 0;
      return;
    end
    rdy = (mq.size() < DEPTH) && !flush;
    if (ack || err) begin
      if (drop > 0) drop--;
      else begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].load && !mq[i].got) begin
            h = mq[i]; h.got = 1; h.data = q_in; h.err = err; mq[i] = h;
            break;
          end
        end
      end
    end
    e_valid = 0; e_we = 0; e_err = 0;
    if (flush) begin
      drop += unanswered(0);
      mq.delete();
    end else begin
      fault = 0;
      if (mq.size() > 0 && (!mq[0].load || mq[0].got)) begin
        h = mq.pop_front();
        e_valid = 1;
        e_pc    = h.pc;
        e_dst   = h.dst;
        e_err   = h.load && h.err;
        e_we    = (h.dst != 0) && !e_err;
        e_r     = h.load ? ref_load(h.data, h.adr, h.size, h.uns) : h.r;
        if (e_err) begin e_bad = h.adr; fault = 1; end
      end
      if (fault) begin
        drop += unanswered(0);
        mq.delete();
        if (mem_valid && rdy && mem_load) drop++;
      end else if (mem_valid && rdy) begin
        n = '{pc: mem_pc, dst: mem_dst, r: mem_r, load: mem_load, size: mem_size,
              uns: mem_uns, adr: mem_adr, got: 0, err: 0, data: 0};
        mq.push_back(n);
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: check the combinational ready before the edge, then advance
  // the model and compare every registered output just after the edge.
  task automatic cycle();
    #2;
    check("mem_ready", mem_ready_o, exp_ready());
    @(posedge clk);
    #1;
    model_step();
    check("wb_valid", wb_valid_o, e_valid);
    check("wb_we", wb_we_o, e_we);
    check("wb_err", wb_err_o, e_err);
    check("wb_pc", wb_pc_o, e_pc);
    check("wb_dst", wb_dst_o, e_dst);
    check("wb_r", wb_r_o, e_r);
    check("wb_badaddr", wb_badaddr_o, e_bad);
    check("occupancy", occupancy_o, mq.size());
  endtask

  task automatic idle();
    mem_valid = 0; mem_load = 0; mem_uns = 0; mem_size = 0;
    mem_pc = 0; mem_dst = 0; mem_r = 0; mem_adr = 0;
    ack = 0; err = 0; q_in = 0; flush = 0;
  endtask

  task automatic alu(logic [31:0] pc, logic [4:0] dst, logic [31:0] r);
    idle();
    mem_valid = 1; mem_pc = pc; mem_dst = dst; mem_r = r;
  endtask

  task automatic load(logic [31:0] pc, logic [4:0] dst, logic [31:0] adr,
                      logic [1:0] size, logic uns);
    idle();
    mem_valid = 1; mem_load = 1; mem_pc = pc; mem_dst = dst;
    mem_adr = adr; mem_size = size; mem_uns = uns; mem_r = 32'hDEAD_BEEF;
  endtask

  task automatic respond(logic [31:0] data);
    idle();
    ack = 1; q_in = data;
  endtask

  logic [31:0] ld_data [4];

  initial begin
    idle();
    drop = 0;

    // Reset: outputs at reset values, not ready while reset is held.
    rst = 1;
    cycle();
    cycle();
    check("rst_pc_init", wb_pc_o, PC_INIT);
    check("rst_ready_low", mem_ready_o, 1'b0);
    rst = 0;
    cycle();
    check("ready_after_rst", mem_ready_o, 1'b1);

    // ALU op with a destination, then one to x0.
    alu(32'h1000, 5'd5, 32'h1234);  cycle();
    idle();                         cycle();
    check("alu_valid", wb_valid_o, 1'b1);
    check("alu_we", wb_we_o, 1'b1);
    check("alu_dst", wb_dst_o, 5'd5);
    check("alu_r", wb_r_o, 32'h1234);
    alu(32'h1004, 5'd0, 32'h5555);  cycle();
    idle();                         cycle();
    check("alu_x0_we", wb_we_o, 1'b0);
    cycle();
    check("valid_pulse", wb_valid_o, 1'b0);

    // Load alignment and extension, each answered one cycle after enqueue
    // so the response bypasses straight into writeback.
    load(32'h1100, 5'd3, 32'h0000_1003, 2'd0, 1'b0); cycle();
    respond(32'h80FF_FFFF);                           cycle();
    check("lb_bypass_valid", wb_valid_o, 1'b1);
    check("lb_sext", wb_r_o, 32'hFFFF_FF80);
    load(32'h1104, 5'd3, 32'h0000_1003, 2'd0, 1'b1); cycle();
    respond(32'h80FF_FFFF);                           cycle();
    check("lbu_zext", wb_r_o, 32'h0000_0080);
    load(32'h1108, 5'd4, 32'h0000_1002, 2'd1, 1'b0); cycle();
    respond(32'h7FFF_0000);                           cycle();
    check("lh_pos", wb_r_o, 32'h0000_7FFF);
    load(32'h110C, 5'd4, 32'h0000_1000, 2'd3, 1'b1); cycle();
    respond(32'h8765_4321);                           cycle();
    check("ld_as_word", wb_r_o, 32'h8765_4321);

    // Fill the queue with four loads; an ALU op is held off until a slot
    // frees, and the freeing retirement does not raise ready that cycle.
    for (int i = 0; i < 4; i++) begin
      ld_data[i] = $urandom;
      load(32'h2000 + 32'(4 * i), 5'(8 + i), 32'h0000_2000 + 32'(4 * i), 2'd2, 1'b0);
      cycle();
    end
    alu(32'h3000, 5'd7, 32'hABCD);
    cycle();
    check("full_occ", occupancy_o, 3'd4);
    check("full_ready", mem_ready_o, 1'b0);
    ack = 1; q_in = ld_data[0];
    cycle();
    check("full_ret0", wb_r_o, ld_data[0]);
    check("full_occ_after_ret", occupancy_o, 3'd3);
    ack = 0;
    cycle();
    check("full_alu_enq", occupancy_o, 3'd4);
    for (int i = 1; i < 4; i++) begin
      respond(ld_data[i]);
      cycle();
      check("full_inorder", wb_pc_o, 32'h2000 + 32'(4 * i));
    end
    idle();
    cycle();
    check("full_alu_last", wb_pc_o, 32'h3000);
    check("full_alu_r", wb_r_o, 32'hABCD);

    // Faulting load A discards B and C; C's late response is dropped.
    load(32'h4000, 5'd1, 32'h0000_4008, 2'd2, 1'b0); cycle();
    alu(32'h4004, 5'd2, 32'h1111);                   cycle();
    load(32'h4008, 5'd3, 32'h0000_400C, 2'd2, 1'b0); cycle();
    idle(); err = 1;                                  cycle();
    check("fault_err", wb_err_o, 1'b1);
    check("fault_we", wb_we_o, 1'b0);
    check("fault_badaddr", wb_badaddr_o, 32'h0000_4008);
    check("fault_occ", occupancy_o, 3'd0);
    respond(32'h9999_9999);                           cycle();
    check("fault_drop_valid", wb_valid_o, 1'b0);
    check("fault_drop_occ", occupancy_o, 3'd0);

    // Flush with two loads outstanding; both responses are dropped, then a
    // fresh load completes normally.
    load(32'h5000, 5'd5, 32'h0000_5000, 2'd2, 1'b0); cycle();
    load(32'h5004, 5'd6, 32'h0000_5004, 2'd2, 1'b0); cycle();
    idle(); flush = 1;                                cycle();
    check("flush_no_ret", wb_valid_o, 1'b0);
    check("flush_occ", occupancy_o, 3'd0);
    respond(32'h1111_1111);                           cycle();
    respond(32'h2222_2222);                           cycle();
    check("flush_drop_valid", wb_valid_o, 1'b0);
    load(32'h5008, 5'd9, 32'h0000_5001, 2'd0, 1'b1);  cycle();
    respond(32'h0000_AB00);                           cycle();
    check("flush_new_valid", wb_valid_o, 1'b1);
    check("flush_new_r", wb_r_o, 32'h0000_00AB);
    idle();
    cycle();

    // Randomized traffic, including faults, flushes and mid-stream resets.
    for (int n = 0; n < 3000; n++) begin
      int roll;
      idle();
      rst       = ($urandom_range(0, 199) == 0);
      mem_valid = ($urandom_range(0, 99) < 60);
      mem_load  = $urandom_range(0, 1);
      mem_size  = 2'($urandom_range(0, 3));
      mem_uns   = $urandom_range(0, 1);
      mem_pc    = $urandom;
      mem_dst   = 5'($urandom_range(0, 31));
      mem_r     = $urandom;
      mem_adr   = $urandom;
      q_in      = $urandom;
      roll      = $urandom_range(0, 99);
      ack       = (roll < 35);
      err       = (roll >= 35 && roll < 40);
      flush     = ($urandom_range(0, 99) < 3);
      cycle();
    end
    rst = 0;
    idle();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_wb_loadq.md
RISCV_WB_LOADQ -- requirements
Module: riscv_wb_loadq

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4, queue entries; power of 2, range 2..16.
REQ-003 Parameter PC_INIT, default 'h200, reset value of wb_pc_o.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 mem_valid_i  input  1  instruction presented by memory stage (not a bubble).
REQ-007 mem_ready_o  output  1  queue accepts an instruction this cycle.
REQ-008 mem_pc_i  input  XLEN  instruction PC.
REQ-009 mem_dst_i  input  5  destination register.
REQ-010 mem_r_i  input  XLEN  execute result for non-load instructions.
REQ-011 mem_load_i  input  1  instruction is a load awaiting a data-memory response.
REQ-012 mem_size_i  input  2  load size: 0 byte, 1 half, 2 word, 3 double.
REQ-013 mem_unsigned_i  input  1  zero-extend load (LBU/LHU/LWU).
REQ-014 mem_memadr_i  input  XLEN  load address.
REQ-015 dmem_ack_i, dmem_err_i  input  1 each  in-order load response / access fault.
REQ-016 dmem_q_i  input  XLEN  load response data, valid with dmem_ack_i.
REQ-017 flush_i  input  1  discard all queued instructions.
REQ-018 wb_valid_o, wb_we_o, wb_err_o  output  1 each  retire strobe, register-file write enable, load fault.
REQ-019 wb_pc_o, wb_r_o, wb_badaddr_o  output  XLEN each  retired PC, write data, faulting address.
REQ-020 wb_dst_o  output  5  register-file destination.
REQ-021 occupancy_o  output  $clog2(DEPTH)+1  valid queue entries.

Function
REQ-022 mem_ready_o SHALL be 1 iff occupancy_o < DEPTH and flush_i=0; a retirement in the same cycle SHALL NOT raise it.
REQ-023 An enqueue SHALL occur when mem_valid_i & mem_ready_o; queue order SHALL be program order.
REQ-024 A response pointer SHALL track the oldest queued load without a response; each dmem_ack_i or dmem_err_i SHALL store the data and error flag in that entry and advance the pointer.
REQ-025 A response arriving with no outstanding load and a zero drop counter SHALL be ignored.
REQ-026 The head SHALL retire when it is a non-load, or a load whose response is stored or arrives this cycle (bypass); one retirement per cycle at most.
REQ-027 Retirement SHALL register, next cycle: wb_valid_o=1; wb_pc_o and wb_dst_o from the entry; wb_we_o=(dst!=0)&~err; wb_err_o=err.
REQ-028 wb_r_o: non-load gets mem_r_i; load gets data shifted right by 8*adr[1:0] (XLEN=32) or 8*adr[2:0] (XLEN=64), truncated to size, sign- or zero-extended to XLEN.
REQ-029 For XLEN=32, size 3 SHALL be treated as word; unsigned word SHALL equal signed word.
REQ-030 wb_badaddr_o SHALL load mem_memadr of the retiring entry when err=1, else hold.
REQ-031 Faulting-load retirement SHALL discard all younger entries in the same cycle; outstanding discarded loads SHALL be added to a drop counter.
REQ-032 flush_i=1 SHALL discard all entries without retiring any, add outstanding loads to the drop counter, ignore enqueue that cycle.
REQ-033 While the drop counter is nonzero, each response SHALL decrement it and be discarded; responses for live loads follow.
REQ-034 A response in the flush/fault cycle SHALL apply to the entry it targets before the discard is counted; the count SHALL exclude it.
REQ-035 Simultaneous enqueue and retire SHALL leave occupancy_o unchanged; pointers SHALL wrap modulo DEPTH.
REQ-036 wb_valid_o, wb_we_o, wb_err_o SHALL be single-cycle pulses per retirement.

Reset
REQ-037 rst_i=1 SHALL clear queue, pointers, drop counter; occupancy_o=0, mem_ready_o=0 during reset, 1 after.
REQ-038 Reset values: wb_valid_o=0, wb_we_o=0, wb_err_o=0, wb_dst_o=0, wb_r_o=0, wb_badaddr_o=0, wb_pc_o=PC_INIT.
REQ-039 Reset mid-operation SHALL abandon outstanding loads; responses after reset SHALL be ignored per REQ-025.

Verification
REQ-040 ALU op dst=5, r=0x1234 -> next cycle wb_valid_o=1, wb_we_o=1, wb_dst_o=5, wb_r_o=0x1234; dst=0 -> wb_we_o=0.
REQ-041 XLEN=32 LB adr=0x...3, dmem_q_i=0x80FF_FFFF -> wb_r_o=0xFFFF_FF80; LBU -> 0x0000_0080; LH adr=2 q=0x7FFF_0000 -> 0x0000_7FFF.
REQ-042 DEPTH=4: four loads then ALU op -> mem_ready_o=0, occupancy_o=4; one ack -> load retires, ALU op enqueued next cycle; in-order retirement.
REQ-043 Load A, ALU B, load C queued; dmem_err_i for A -> wb_err_o=1, wb_we_o=0, wb_badaddr_o=adr(A); B, C discarded; next ack dropped, occupancy_o=0.
REQ-044 Two loads outstanding, flush_i pulse -> no retirement; next two acks dropped; new load enqueued, its ack retires with correct data.
REQ-045 Ack bypass: load at head, ack in cycle N -> wb_valid_o=1 in cycle N+1 with aligned dmem_q_i data.
